reg_select_seq: RTL and testbench

// - Instruction register plus operand-select sequencer that sits directly upstream of the 4-to-16 register decoder.
// - Latches a 32-bit instruction and steps through its register operands, one per cycle.
// - Each cycle it presents a 4-bit register index (reg_idx) for the decoder, with a read (rout) or write (rin) strobe.
// - Also produces the sign-extended immediate for the bus.

---
 rtl/reg_select_seq_if.sv | 28 ++
 rtl/reg_select_seq.sv | 109 ++++++++++
 tb/tb_reg_select_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/reg_select_seq_if.sv
// Operand-select bus between the instruction/sequencer block and its user.
// master drives instruction load and start; slave returns decoder selects and strobes.
interface reg_select_seq_if #(
  parameter int unsigned DATA_W = 32
);
  logic              ir_load;
  logic [DATA_W-1:0] instr_in;
  logic              start;
  logic [DATA_W-1:0] ir;
  logic [3:0]        reg_idx;
  logic              rout;
  logic              rin;
  logic              r0_zero;
  logic              c_out;
  logic [DATA_W-1:0] c_sext;
  logic              busy;
  logic              done;

  modport master (
    output ir_load, instr_in, start,
    input  ir, reg_idx, rout, rin, r0_zero, c_out, c_sext, busy, done
  );

  modport slave (
    input  ir_load, instr_in, start,
    output ir, reg_idx, rout, rin, r0_zero, c_out, c_sext, busy, done
  );
endinterface

// File: rtl/reg_select_seq.sv
// Instruction register plus operand sequencer feeding the 4-to-16 register decoder.
// Steps through Rb/Rc/immediate/Ra one per cycle with registered strobes.
module reg_select_seq #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned C_W    = 19
) (
  input logic             clk_i,
  input logic             clr_i,
  reg_select_seq_if.slave bus_io
);

  typedef enum logic [2:0] {StIdle, StRdB, StRdC, StImm, StWrA, StDone} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [3:0]        reg_idx_q, reg_idx_d;
  logic              rout_q, rout_d;
  logic              rin_q, rin_d;
  logic              c_out_q, c_out_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [1:0]        op_class;

  // ir_d equals ir_q outside IDLE, so this also serves the mid-sequence branch.
  assign op_class = ir_d[31:30];

  always_comb begin
    ir_d    = ir_q;
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.ir_load) ir_d = bus_io.instr_in;
        if (bus_io.start) state_d = (op_class == 2'b11) ? StDone : StRdB;
      end
      StRdB: begin
        unique case (op_class)
          2'b00:   state_d = StRdC;
          2'b01:   state_d = StImm;
          default: state_d = StWrA;
        endcase
      end
      StRdC:   state_d = StWrA;
      StImm:   state_d = StWrA;
      StWrA:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered with it.
  always_comb begin
    reg_idx_d = 4'd0;
    rout_d    = 1'b0;
    rin_d     = 1'b0;
    c_out_d   = 1'b0;
    done_d    = 1'b0;
    busy_d    = (state_d != StIdle);
    unique case (state_d)
      StRdB: begin
        reg_idx_d = ir_d[22:19];
        rout_d    = 1'b1;
      end
      StRdC: begin
        reg_idx_d = ir_d[18:15];
        rout_d    = 1'b1;
      end
      StImm:   c_out_d = 1'b1;
      StWrA: begin
        reg_idx_d = ir_d[26:23];
        rin_d     = 1'b1;
      end
      StDone:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q   <= StIdle;
      ir_q      <= '0;
      reg_idx_q <= 4'd0;
      rout_q    <= 1'b0;
      rin_q     <= 1'b0;
      c_out_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      reg_idx_q <= reg_idx_d;
      rout_q    <= rout_d;
      rin_q     <= rin_d;
      c_out_q   <= c_out_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus_io.ir      = ir_q;
  assign bus_io.reg_idx = reg_idx_q;
  assign bus_io.rout    = rout_q;
  assign bus_io.rin     = rin_q;
  assign bus_io.c_out   = c_out_q;
  assign bus_io.done    = done_q;
  assign bus_io.busy    = busy_q;
  assign bus_io.r0_zero = rout_q & (reg_idx_q == 4'd0);
  assign bus_io.c_sext  = {{(DATA_W - C_W){ir_q[C_W-1]}}, ir_q[C_W-1:0]};

endmodule

// File: tb/tb_reg_select_seq.sv
// Randomised and directed check of reg_select_seq against a queue-based operand-list model.
module tb_reg_select_seq;

  logic clk = 1'b0;
  logic clr;

  reg_select_seq_if #(.DATA_W(32)) bus ();

  reg_select_seq #(
    .DATA_W(32),
    .C_W   (19)
  ) dut (
    .clk_i (clk),
    .clr_i (clr),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic [3:0] idx;
    logic       rout;
    logic       rin;
    logic       cout;
    logic       done;
  } step_t;

  step_t       pend[$];
  step_t       cur;
  logic [31:0] ir_m;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic step_t mk(input logic [3:0] idx, input logic ro, input logic ri,
                               input logic co, input logic dn);
    step_t s;
    s.busy = 1'b1;
    s.idx  = idx;
    s.rout = ro;
    s.rin  = ri;
    s.cout = co;
    s.done = dn;
    return s;
  endfunction

  // Operand list for an instruction: one entry per cycle after the start edge.
  task automatic build(input logic [31:0] ins);
    logic [3:0] ra, rb, rc;
    ra = ins[26:23];
    rb = ins[22:19];
    rc = ins[18:15];
    case (ins[31:30])
      2'b00: begin
        pend.push_back(mk(rb, 1, 0, 0, 0));
        pend.push_back(mk(rc, 1, 0, 0, 0));
        pend.push_back(mk(ra, 0, 1, 0, 0));
      end
      2'b01: begin
        pend.push_back(mk(rb, 1, 0, 0, 0));
        pend.push_back(mk(4'd0, 0, 0, 1, 0));
        pend.push_back(mk(ra, 0, 1, 0, 0));
      end
      2'b10: begin
        pend.push_back(mk(rb, 1, 0, 0, 0));
        pend.push_back(mk(ra, 0, 1, 0, 0));
      end
      default: ;
    endcase
    pend.push_back(mk(4'd0, 0, 0, 0, 1));
  endtask

  task automatic model_edge(input logic c, input logic ld, input logic st,
                            input logic [31:0] instr);
    if (c) begin
      ir_m = '0;
      pend.delete();
      cur = '0;
    end else begin
      if (!cur.busy) begin
        if (ld) ir_m = instr;
        if (st) build(ir_m);
      end
      cur = (pend.size() > 0) ? pend.pop_front() : step_t'(0);
    end
  endtask

  task automatic compare();
    logic [31:0] sext;
    // Two's-complement value of the 19-bit field, wrapped to 32 bits.
    sext = {13'd0, ir_m[18:0]} - (ir_m[18] ? 32'h0008_0000 : 32'd0);
    chk("ir",      bus.ir,      ir_m);
    chk("reg_idx", 32'(bus.reg_idx), 32'(cur.idx));
    chk("rout",    32'(bus.rout),    32'(cur.rout));
    chk("rin",     32'(bus.rin),     32'(cur.rin));
    chk("c_out",   32'(bus.c_out),   32'(cur.cout));
    chk("done",    32'(bus.done),    32'(cur.done));
    chk("busy",    32'(bus.busy),    32'(cur.busy));
    chk("r0_zero", 32'(bus.r0_zero), 32'(cur.rout && cur.idx == 4'd0));
    chk("c_sext",  bus.c_sext,  sext);
  endtask

  task automatic cyc(input logic c, input logic ld, input logic st, input logic [31:0] instr);
    clr          = c;
    bus.ir_load  = ld;
    bus.start    = st;
    bus.instr_in = instr;
    @(posedge clk);
    model_edge(c, ld, st, instr);
    #1;
    compare();
  endtask

  initial begin
    cur  = '0;
    ir_m = '0;

    // Reset with load/start held high: clr must win.
    cyc(1, 1, 1, 32'hDEAD_BEEF);
    cyc(1, 1, 1, 32'hDEAD_BEEF);
    chk("rst_ir",   bus.ir, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);

    // 3-reg: Ra=3, Rb=5, Rc=7.
    cyc(0, 1, 0, 32'h01AB_8000);
    chk("r3_ir", bus.ir, 32'h01AB_8000);
    cyc(0, 0, 1, 32'h0);
    chk("r3_rdb", {bus.rout, 3'b0, bus.reg_idx}, 32'h85);
    cyc(0, 0, 0, 32'h0);
    chk("r3_rdc", {bus.rout, 3'b0, bus.reg_idx}, 32'h87);
    cyc(0, 0, 0, 32'h0);
    chk("r3_wra", {bus.rin, 3'b0, bus.reg_idx}, 32'h83);
    cyc(0, 0, 0, 32'h0);
    chk("r3_done", 32'(bus.done), 32'h1);
    cyc(0, 0, 0, 32'h0);
    chk("r3_idle", 32'(bus.busy), 32'h0);

    // Immediate op=01, Ra=2, Rb=0, C=0x7FFFF; load and start together.
    cyc(0, 1, 1, 32'h4107_FFFF);
    chk("imm_r0", {bus.rout, bus.r0_zero, 2'b0, bus.reg_idx}, 32'hC0);
    cyc(0, 0, 0, 32'h0);
    chk("imm_sext", bus.c_sext, 32'hFFFF_FFFF);
    chk("imm_cout", 32'(bus.c_out), 32'h1);
    cyc(0, 0, 0, 32'h0);
    chk("imm_wra", {bus.rin, 3'b0, bus.reg_idx}, 32'h82);
    cyc(0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0);

    // No-operand op; start during DONE is dropped.
    cyc(0, 1, 0, 32'hC000_0000);
    cyc(0, 0, 1, 32'h0);
    chk("nop_done", 32'(bus.done), 32'h1);
    cyc(0, 0, 1, 32'h0);
    chk("nop_idle", 32'(bus.busy), 32'h0);
    cyc(0, 0, 0, 32'h0);

    // Load attempt mid-sequence is ignored.
    cyc(0, 1, 1, 32'h01AB_8000);
    cyc(0, 1, 0, 32'hFFFF_FFFF);
    chk("mid_ir", bus.ir, 32'h01AB_8000);
    cyc(0, 0, 0, 32'h0);
    chk("mid_wra", {bus.rin, 3'b0, bus.reg_idx}, 32'h83);
    cyc(0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0);

    // clr while in RD_C, then a clean rerun.
    cyc(0, 1, 1, 32'h01AB_8000);
    cyc(0, 0, 0, 32'h0);
    cyc(1, 1, 1, 32'h01AB_8000);
    chk("clr_ir", bus.ir, 32'h0);
    chk("clr_busy", 32'(bus.busy), 32'h0);
    cyc(0, 1, 1, 32'h01AB_8000);
    cyc(0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0);
    chk("rerun_done", 32'(bus.done), 32'h1);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) == 0), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
